// File: rtl/mole_round_scheduler.sv
// -----------------------------------------------------------------------------
// mole_round_scheduler
//
// Game sequencer for the whack-a-mole datapath. Picks which single mole LED is
// lit, how long it stays up, and whether the player whacked it in time. Emits
// one-clock hit/miss strobes for the score counter and tracks level and lives.
// Everything runs on clk; tick_en qualifies the game-time counters.
//
// Optional build feature (macro MOLE_PENALTY_EN):
//   defined   - a toggle on an unlit switch while a mole is up costs a life
//               (priority: hit > wrong toggle > expiry).
//   undefined - wrong toggles are ignored and no penalty logic exists.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset, clears all state
//   tick_en    in   one-clock game tick strobe
//   start      in   level-sensitive start/restart request (debounced)
//   rnd        in   free-running LFSR value, sampled only in SPAWN
//   sw         in   raw asynchronous switches, one per mole
//   mole       out  one-hot lit-mole mask, 0 when no mole is up
//   hit_pulse  out  one-clock strobe per hit
//   miss_pulse out  one-clock strobe per life lost
//   level      out  current level, 1..MAX_LEVEL
//   lives      out  remaining lives
//   busy       out  high while in SPAWN, UP or GAP
//   game_over  out  high while in OVER
//
// NUM_MOLES must be a power of two so the mole index wraps naturally.
// -----------------------------------------------------------------------------
module mole_round_scheduler #(
    parameter int NUM_MOLES     = 8,
    parameter int LIVES         = 3,
    parameter int BASE_UP_TICKS = 8,
    parameter int GAP_TICKS     = 2,
    parameter int LEVEL_STEP    = 10,
    parameter int MAX_LEVEL     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_en,
    input  logic                 start,
    input  logic [7:0]           rnd,
    input  logic [NUM_MOLES-1:0] sw,
    output logic [NUM_MOLES-1:0] mole,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [2:0]           level,
    output logic [1:0]           lives,
    output logic                 busy,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(NUM_MOLES);

    localparam logic [2:0] LEVEL_ONE_C = 3'd1;
    localparam logic [2:0] MAX_LEVEL_C = 3'(MAX_LEVEL);
    localparam logic [1:0] LIVES_C     = 2'(LIVES);
    localparam logic [7:0] BASE_UP_C   = 8'(BASE_UP_TICKS);
    localparam logic [7:0] GAP_C       = 8'(GAP_TICKS);
    localparam logic [7:0] HIT_LAST_C  = 8'(LEVEL_STEP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_UP    = 3'd2,
        ST_GAP   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_MOLES-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_MOLES-1:0] mole_q, mole_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [2:0]           level_q, level_d;
    logic [1:0]           lives_q, lives_d;
    logic                 busy_q, busy_d;
    logic                 game_over_q, game_over_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [7:0]           hit_cnt_q, hit_cnt_d;
    logic [7:0]           up_cnt_q, up_cnt_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;

    logic [NUM_MOLES-1:0] tog_s;
    logic [IDX_W-1:0]     raw_idx_s, spawn_idx_s;
    logic                 hit_s, expire_s, lose_s;
    logic                 unused_rnd_s;

    // One-hot mask with only bit idx set.
    function automatic logic [NUM_MOLES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MOLES-1:0] v;
        v      = {NUM_MOLES{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Up window shrinks by one tick per level but never drops below one tick.
    function automatic logic [7:0] up_window(input logic [2:0] lvl);
        logic [7:0] off;
        off = {5'b00000, lvl} - 8'd1;
        if (off >= BASE_UP_C) begin
            return 8'd1;
        end else begin
            return BASE_UP_C - off;
        end
    endfunction

    // Only the low index bits of the random source are needed.
    assign unused_rnd_s = ^rnd[7:IDX_W];

    // Two-flop synchronizer followed by the previous-value register used for
    // edge detection; every bit change in either direction is a whack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {NUM_MOLES{1'b0}};
            sync2_q <= {NUM_MOLES{1'b0}};
            prev_q  <= {NUM_MOLES{1'b0}};
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tog_s     = sync2_q ^ prev_q;
    assign raw_idx_s = rnd[IDX_W-1:0];
    // Never light the same mole twice in a row: bump to the next one (wraps).
    assign spawn_idx_s = (raw_idx_s == last_idx_q) ?
                         (raw_idx_s + {{(IDX_W-1){1'b0}}, 1'b1}) : raw_idx_s;

    assign hit_s    = |(tog_s & mole_q);
    assign expire_s = tick_en && (up_cnt_q <= 8'd1);

`ifdef MOLE_PENALTY_EN
    logic wrong_s;
    assign wrong_s = |(tog_s & ~mole_q);
    // A hit always wins; otherwise a wrong toggle or an expiry costs a life.
    assign lose_s  = !hit_s && (wrong_s || expire_s);
`else
    // A hit always wins over an expiry landing in the same clock.
    assign lose_s  = !hit_s && expire_s;
`endif

    // Next-state and next-output logic of the game sequencer.
    always_comb begin
        state_d    = state_q;
        mole_d     = mole_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        level_d    = level_q;
        lives_d    = lives_q;
        last_idx_d = last_idx_q;
        hit_cnt_d  = hit_cnt_q;
        up_cnt_d   = up_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                mole_d = {NUM_MOLES{1'b0}};
                if (start) begin
                    lives_d   = LIVES_C;
                    level_d   = LEVEL_ONE_C;
                    hit_cnt_d = 8'd0;
                    state_d   = ST_SPAWN;
                end else begin
                    state_d   = state_q;
                end
            end

            ST_SPAWN: begin
                mole_d     = onehot(spawn_idx_s);
                last_idx_d = spawn_idx_s;
                up_cnt_d   = up_window(level_q);
                state_d    = ST_UP;
            end

            ST_UP: begin
                if (hit_s) begin
                    hit_d     = 1'b1;
                    mole_d    = {NUM_MOLES{1'b0}};
                    gap_cnt_d = GAP_C;
                    state_d   = ST_GAP;
                    // Every LEVEL_STEP-th hit advances the level; the hit
                    // counter still wraps once the level has saturated.
                    if (hit_cnt_q >= HIT_LAST_C) begin
                        hit_cnt_d = 8'd0;
                        if (level_q >= MAX_LEVEL_C) begin
                            level_d = MAX_LEVEL_C;
                        end else begin
                            level_d = level_q + 3'd1;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + 8'd1;
                    end
                end else if (lose_s) begin
                    miss_d  = 1'b1;
                    mole_d  = {NUM_MOLES{1'b0}};
                    lives_d = (lives_q == 2'd0) ? 2'd0 : (lives_q - 2'd1);
                    if (lives_q <= 2'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        gap_cnt_d = GAP_C;
                        state_d   = ST_GAP;
                    end
                end else if (tick_en) begin
                    up_cnt_d = up_cnt_q - 8'd1;
                end else begin
                    up_cnt_d = up_cnt_q;
                end
            end

            ST_GAP: begin
                mole_d = {NUM_MOLES{1'b0}};
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_SPAWN;
                end else if (tick_en) begin
                    if (gap_cnt_q == 8'd1) begin
                        state_d = ST_SPAWN;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q;
                end
            end

            default: begin
                mole_d  = {NUM_MOLES{1'b0}};
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d == ST_SPAWN) || (state_d == ST_UP) || (state_d == ST_GAP);
        game_over_d = (state_d == ST_OVER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mole_q      <= {NUM_MOLES{1'b0}};
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            level_q     <= LEVEL_ONE_C;
            lives_q     <= LIVES_C;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            last_idx_q  <= {IDX_W{1'b0}};
            hit_cnt_q   <= 8'd0;
            up_cnt_q    <= 8'd0;
            gap_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            mole_q      <= mole_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
            last_idx_q  <= last_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            up_cnt_q    <= up_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign mole       = mole_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign busy       = busy_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for mole_round_scheduler. Randomised rounds are checked against a
// round-level game model (lives, level, hit count, last mole) kept here.
// -----------------------------------------------------------------------------
module tb_mole_round_scheduler;
    logic       clk, rst, tick_en, start;
    logic [7:0] rnd, sw, mole;
    logic       hit_pulse, miss_pulse, busy, game_over;
    logic [2:0] level;
    logic [1:0] lives;

    int checks, failures;
    int m_lives, m_level, m_hits, m_last, m_idx;

    mole_round_scheduler dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .rnd(rnd),
        .sw(sw), .mole(mole), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .level(level), .lives(lives), .busy(busy), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model (game rules) ----------------
    function automatic int pick_idx(input int r, input int last);
        int i;
        i = r % 8;
        if (i == last) i = (i + 1) % 8;
        return i;
    endfunction

    function automatic int window(input int lvl);
        int w;
        w = 8 - (lvl - 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [7:0] onehot8(input int i);
        logic [7:0] v;
        v    = 8'd0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_hit();
        m_hits++;
        if (m_hits == 10) begin
            m_hits = 0;
            if (m_level < 7) m_level++;
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick_en = 1'b0; start = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        m_last = 0; m_idx = 0; m_lives = 3; m_level = 1; m_hits = 0;
    endtask

    // Ticks every clock until a mole lights (bounded); returns the mask seen.
    task automatic spawn_next(input logic [7:0] r, output logic [7:0] seen);
        rnd  = r;
        seen = 8'd0;
        for (int c = 0; c < 20; c++) begin
            tick_en = 1'b1;
            step();
            if (mole !== 8'd0) begin
                seen = mole;
                break;
            end
        end
        tick_en = 1'b0;
    endtask

    task automatic start_game(input logic [7:0] r, output logic [7:0] seen);
        start = 1'b1; rnd = r;
        step();
        start = 1'b0;
        m_lives = 3; m_level = 1; m_hits = 0;
        spawn_next(r, seen);
    endtask

    // Toggle switch i, sample pulses over the next four clocks.
    task automatic whack(input int i, input bit tick_last, output logic [3:0] hp,
                         output logic [3:0] mp, output logic [7:0] mole_after);
        sw[i] = ~sw[i];
        for (int k = 0; k < 4; k++) begin
            tick_en = (k == 2) ? tick_last : 1'b0;
            step();
            hp[k] = hit_pulse;
            mp[k] = miss_pulse;
            if (k == 2) mole_after = mole;
        end
        tick_en = 1'b0;
    endtask

    // Tick every clock until miss_pulse (bounded); returns tick number or -1.
    task automatic expire(output int miss_at, output logic [7:0] mole_after);
        miss_at = -1;
        for (int t = 1; t <= 20; t++) begin
            tick_en = 1'b1;
            step();
            if (miss_pulse === 1'b1) begin
                miss_at = t;
                break;
            end
        end
        tick_en    = 1'b0;
        mole_after = mole;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; tick_en = 1'b0; start = 1'b0; rnd = 8'd0; sw = 8'd0;
        step(); step();
        checks++; if ({mole, hit_pulse, miss_pulse, busy, game_over} !== 12'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", {mole, hit_pulse, miss_pulse, busy, game_over}); end
        checks++; if ({level, lives} !== {3'd1, 2'd3}) begin
            failures++; $display("FAIL reset_level_lives: got %0d/%0d expected 1/3", level, lives); end
        rst = 1'b0;
        step(); step(); step();
        checks++; if ({mole, busy} !== 9'd0) begin
            failures++; $display("FAIL idle_hold: got %h expected 0", {mole, busy}); end
        m_last = 0; m_lives = 3; m_level = 1; m_hits = 0;
    endtask

    task automatic test_start_hit();
        logic [7:0] seen, ma;
        logic [3:0] hp, mp;
        reset_dut();
        start = 1'b1; rnd = 8'h05;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || mole !== 8'd0) begin
            failures++; $display("FAIL start_spawn: busy=%b mole=%h expected busy=1 mole=00", busy, mole); end
        m_lives = 3; m_level = 1; m_hits = 0;
        spawn_next(8'h05, seen);
        m_idx = pick_idx(5, m_last); m_last = m_idx;
        checks++; if (seen !== 8'b0010_0000) begin
            failures++; $display("FAIL first_mole: got %h expected 20", seen); end
        checks++; if ({busy, level, lives} !== {1'b1, 3'd1, 2'd3}) begin
            failures++; $display("FAIL first_status: got %b expected 1_001_11", {busy, level, lives}); end
        whack(5, 1'b0, hp, mp, ma);
        model_hit();
        checks++; if (hp !== 4'b0100 || mp !== 4'b0000) begin
            failures++; $display("FAIL hit_latency: hp=%b mp=%b expected 0100/0000", hp, mp); end
        checks++; if (ma !== 8'd0) begin
            failures++; $display("FAIL hit_mole_clear: got %h expected 00", ma); end
        // Two gap ticks, then the SPAWN clock, then the new mole.
        rnd = 8'hF5;
        tick_en = 1'b1; step();
        tick_en = 1'b1; step();
        checks++; if (mole !== 8'd0) begin
            failures++; $display("FAIL gap_dark: got %h expected 00", mole); end
        tick_en = 1'b0; step();
        m_idx = pick_idx(8'hF5, m_last); m_last = m_idx;
        checks++; if (mole !== 8'b0100_0000) begin
            failures++; $display("FAIL repeat_avoid: got %h expected 40", mole); end
    endtask

    task automatic test_expiry();
        logic [7:0] seen, ma, r;
        int at;
        reset_dut();
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        checks++; if (seen !== onehot8(m_idx)) begin
            failures++; $display("FAIL exp_spawn: got %h expected %h", seen, onehot8(m_idx)); end
        for (int n = 0; n < 3; n++) begin
            expire(at, ma);
            m_lives--;
            checks++; if (at !== window(m_level) || ma !== 8'd0 || hit_pulse !== 1'b0) begin
                failures++; $display("FAIL expiry_tick: tick=%0d mole=%h expected tick=%0d mole=00", at, ma, window(m_level)); end
            checks++; if (lives !== 2'(m_lives)) begin
                failures++; $display("FAIL expiry_lives: got %0d expected %0d", lives, m_lives); end
            if (m_lives > 0) begin
                r = 8'($urandom);
                spawn_next(r, seen);
                m_idx = pick_idx(r, m_last); m_last = m_idx;
                checks++; if (seen !== onehot8(m_idx)) begin
                    failures++; $display("FAIL exp_respawn: got %h expected %h", seen, onehot8(m_idx)); end
            end
        end
        step(); step(); tick_en = 1'b1; step(); tick_en = 1'b0;
        checks++; if ({game_over, busy, mole, lives, level} !== {1'b1, 1'b0, 8'd0, 2'd0, 3'd1}) begin
            failures++; $display("FAIL game_over: go=%b busy=%b mole=%h lives=%0d level=%0d", game_over, busy, mole, lives, level); end
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        checks++; if ({game_over, lives, level} !== {1'b0, 2'd3, 3'd1} || seen !== onehot8(m_idx)) begin
            failures++; $display("FAIL restart: go=%b lives=%0d level=%0d mole=%h expected 0/3/1/%h", game_over, lives, level, seen, onehot8(m_idx)); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] seen, ma, r;
        logic [3:0] hp, mp;
        reset_dut();
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        for (int t = 0; t < 7; t++) begin
            tick_en = 1'b1; step();
        end
        tick_en = 1'b0;
        whack(m_idx, 1'b1, hp, mp, ma);
        checks++; if (hp !== 4'b0100 || mp !== 4'b0000 || lives !== 2'd3) begin
            failures++; $display("FAIL hit_beats_expiry: hp=%b mp=%b lives=%0d expected 0100/0000/3", hp, mp, lives); end
    endtask

    task automatic test_wrong_toggle();
        logic [7:0] seen, ma;
        logic [3:0] hp, mp;
        reset_dut();
        start_game(8'h05, seen);
        m_idx = pick_idx(5, m_last); m_last = m_idx;
        whack(0, 1'b0, hp, mp, ma);
`ifdef MOLE_PENALTY_EN
        checks++; if (hp !== 4'b0000 || mp !== 4'b0100 || ma !== 8'd0 || lives !== 2'd2) begin
            failures++; $display("FAIL wrong_penalty: hp=%b mp=%b mole=%h lives=%0d expected 0000/0100/00/2", hp, mp, ma, lives); end
`else
        checks++; if (hp !== 4'b0000 || mp !== 4'b0000 || ma !== 8'h20 || lives !== 2'd3) begin
            failures++; $display("FAIL wrong_ignored: hp=%b mp=%b mole=%h lives=%0d expected 0000/0000/20/3", hp, mp, ma, lives); end
        whack(5, 1'b0, hp, mp, ma);
        checks++; if (hp !== 4'b0100 || ma !== 8'd0) begin
            failures++; $display("FAIL hit_after_wrong: hp=%b mole=%h expected 0100/00", hp, ma); end
`endif
    endtask

    task automatic test_levels();
        logic [7:0] seen, ma, r;
        logic [3:0] hp, mp;
        int at;
        reset_dut();
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        for (int h = 0; h < 76; h++) begin
            // After the first ten hits, spend one round checking the shorter window.
            if (h == 10) begin
                checks++; if (level !== 3'd2) begin
                    failures++; $display("FAIL level_two: got %0d expected 2", level); end
                expire(at, ma);
                m_lives--;
                checks++; if (at !== 7 || lives !== 2'(m_lives)) begin
                    failures++; $display("FAIL window_l2: tick=%0d lives=%0d expected 7/%0d", at, lives, m_lives); end
                r = 8'($urandom);
                spawn_next(r, seen);
                m_idx = pick_idx(r, m_last); m_last = m_idx;
            end
            whack(m_idx, 1'b0, hp, mp, ma);
            model_hit();
            checks++; if (hp !== 4'b0100 || level !== 3'(m_level)) begin
                failures++; $display("FAIL level_hit %0d: hp=%b level=%0d expected 0100/%0d", h, hp, level, m_level); end
            r = 8'($urandom);
            spawn_next(r, seen);
            m_idx = pick_idx(r, m_last); m_last = m_idx;
            checks++; if (seen !== onehot8(m_idx)) begin
                failures++; $display("FAIL level_spawn %0d: got %h expected %h", h, seen, onehot8(m_idx)); end
        end
        checks++; if (level !== 3'd7) begin
            failures++; $display("FAIL level_saturate: got %0d expected 7", level); end
        expire(at, ma);
        checks++; if (at !== 2) begin
            failures++; $display("FAIL window_l7: tick=%0d expected 2", at); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seen, r;
        reset_dut();
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        rst = 1'b1;
        #1;
        checks++; if ({mole, busy, hit_pulse, miss_pulse} !== 11'd0 || lives !== 2'd3 || level !== 3'd1) begin
            failures++; $display("FAIL async_reset: mole=%h busy=%b lives=%0d level=%0d expected 00/0/3/1", mole, busy, lives, level); end
        step();
        rst = 1'b0;
        step(); step();
        checks++; if ({mole, busy, game_over} !== 10'd0) begin
            failures++; $display("FAIL reset_idle: mole=%h busy=%b go=%b expected idle", mole, busy, game_over); end
        m_last = 0;
        start_game(8'h00, seen);
        checks++; if (seen !== 8'b0000_0010) begin
            failures++; $display("FAIL last_idx_reset: got %h expected 02", seen); end
    endtask

    task automatic test_random_rounds();
        logic [7:0] seen, ma, r;
        logic [3:0] hp, mp;
        int at;
        reset_dut();
        r = 8'($urandom);
        start_game(r, seen);
        m_idx = pick_idx(r, m_last); m_last = m_idx;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0 && m_lives > 1) begin
                expire(at, ma);
                m_lives--;
                checks++; if (at !== window(m_level) || lives !== 2'(m_lives)) begin
                    failures++; $display("FAIL rnd_expire %0d: tick=%0d lives=%0d expected %0d/%0d", n, at, lives, window(m_level), m_lives); end
            end else begin
                repeat ($urandom_range(0, 3)) step();
                whack(m_idx, 1'b0, hp, mp, ma);
                model_hit();
                checks++; if (hp !== 4'b0100 || mp !== 4'b0000 || level !== 3'(m_level)) begin
                    failures++; $display("FAIL rnd_hit %0d: hp=%b mp=%b level=%0d expected 0100/0000/%0d", n, hp, mp, level, m_level); end
            end
            r = 8'($urandom);
            spawn_next(r, seen);
            m_idx = pick_idx(r, m_last); m_last = m_idx;
            checks++; if (seen !== onehot8(m_idx)) begin
                failures++; $display("FAIL rnd_spawn %0d: got %h expected %h", n, seen, onehot8(m_idx)); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; tick_en = 1'b0; start = 1'b0; rnd = 8'd0; sw = 8'd0;
        test_reset();
        test_start_hit();
        test_expiry();
        test_simultaneous();
        test_wrong_toggle();
        test_levels();
        test_reset_mid();
        test_random_rounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
